// File: rtl/dsp_seq_divider.sv
`default_nettype none
// ============================================================================
//  Module      : dsp_seq_divider
//  Description : Sequential unsigned restoring divider. Divides a 2*DW-bit
//                dividend by a DW-bit divisor, one quotient bit per clock,
//                with valid/ready handshakes on both sides. Detects divide
//                by zero and quotient overflow up front in a single cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module dsp_seq_divider #(
    parameter int DW     = 18,
    parameter bit OUTREG = 1'b1
) (
    input  logic            CLK,
    input  logic            RSTN,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2*DW-1:0] dividend,
    input  logic [DW-1:0]   divisor,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [DW-1:0]   quotient,
    output logic [DW-1:0]   remainder,
    output logic            div_by_zero,
    output logic            overflow
);

    localparam int              c_CW   = (DW > 1) ? $clog2(DW) : 1;
    localparam logic [c_CW-1:0] c_LAST = c_CW'(DW - 1);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_CHECK = 2'd1;
    localparam logic [1:0] c_RUN   = 2'd2;
    localparam logic [1:0] c_DONE  = 2'd3;

    logic [1:0]      r_state;
    logic [2*DW-1:0] r_dividend;
    logic [DW-1:0]   r_divisor;
    logic [DW:0]     r_prem;      // partial remainder, one guard bit wide
    logic [DW-1:0]   r_shift;     // remaining low dividend bits, MSB next
    logic [DW-1:0]   r_qacc;      // quotient bits collected MSB-first
    logic [c_CW-1:0] r_cnt;
    logic            r_out_valid;
    logic [DW-1:0]   r_quot;
    logic [DW-1:0]   r_rem;
    logic            r_dbz;
    logic            r_ovf;

    logic [DW:0]     w_trial;
    logic            w_ge;
    logic [DW:0]     w_diff;
    logic [DW:0]     w_prem_nxt;
    logic [DW-1:0]   w_qacc_nxt;

    // One restoring step: the trial value is DW+1 bits so a divisor above
    // 2^(DW-1) never loses the bit shifted out of the partial remainder.
    always_comb begin
        w_trial    = (r_prem << 1) | {{DW{1'b0}}, r_shift[DW-1]};
        w_ge       = (w_trial >= {1'b0, r_divisor});
        w_diff     = w_trial - {1'b0, r_divisor};
        w_prem_nxt = w_ge ? w_diff : w_trial;
        w_qacc_nxt = (r_qacc << 1) | {{(DW-1){1'b0}}, w_ge};
    end

    assign in_ready  = RSTN && (r_state == c_IDLE);
    assign out_valid = r_out_valid;

    // Control FSM and datapath registers; results are written only on the
    // edge that raises out_valid so they stay frozen until consumed.
    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            r_state     <= c_IDLE;
            r_dividend  <= '0;
            r_divisor   <= '0;
            r_prem      <= '0;
            r_shift     <= '0;
            r_qacc      <= '0;
            r_cnt       <= '0;
            r_out_valid <= 1'b0;
            r_quot      <= '0;
            r_rem       <= '0;
            r_dbz       <= 1'b0;
            r_ovf       <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (in_valid) begin
                        r_dividend <= dividend;
                        r_divisor  <= divisor;
                        r_dbz      <= 1'b0;
                        r_ovf      <= 1'b0;
                        r_state    <= c_CHECK;
                    end
                end
                c_CHECK: begin
                    if (r_divisor == '0) begin
                        r_dbz       <= 1'b1;
                        r_quot      <= '1;
                        r_rem       <= r_dividend[DW-1:0];
                        r_out_valid <= 1'b1;
                        r_state     <= c_DONE;
                    end else if (r_dividend[2*DW-1:DW] >= r_divisor) begin
                        // Upper half >= divisor means the quotient needs > DW bits.
                        r_ovf       <= 1'b1;
                        r_quot      <= '1;
                        r_rem       <= '0;
                        r_out_valid <= 1'b1;
                        r_state     <= c_DONE;
                    end else begin
                        r_prem  <= {1'b0, r_dividend[2*DW-1:DW]};
                        r_shift <= r_dividend[DW-1:0];
                        r_qacc  <= '0;
                        r_cnt   <= '0;
                        r_state <= c_RUN;
                    end
                end
                c_RUN: begin
                    r_prem  <= w_prem_nxt;
                    r_shift <= r_shift << 1;
                    r_qacc  <= w_qacc_nxt;
                    r_cnt   <= r_cnt + 1'b1;
                    if (r_cnt == c_LAST) begin
                        r_quot      <= w_qacc_nxt;
                        r_rem       <= w_prem_nxt[DW-1:0];
                        r_out_valid <= 1'b1;
                        r_state     <= c_DONE;
                    end
                end
                c_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= c_IDLE;
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    // Output presentation: held registers, or gated to zero when not valid.
    generate
        if (OUTREG) begin : g_outreg
            assign quotient    = r_quot;
            assign remainder   = r_rem;
            assign div_by_zero = r_dbz;
            assign overflow    = r_ovf;
        end else begin : g_outgated
            assign quotient    = r_out_valid ? r_quot : '0;
            assign remainder   = r_out_valid ? r_rem  : '0;
            assign div_by_zero = r_out_valid & r_dbz;
            assign overflow    = r_out_valid & r_ovf;
        end
    endgenerate

endmodule
`default_nettype wire

// File: doc/dsp_seq_divider.md
Name: dsp_seq_divider

Overview:
- Sequential unsigned restoring divider: 2*DW-bit dividend by DW-bit divisor, producing DW-bit quotient and DW-bit remainder.
- Inverse datapath of the 18x18 DSP multiply slice. Consumes a 36-bit product-style operand and recovers the factor plus remainder.
- Valid/ready handshake on both sides. One quotient bit per clock. Non-pipelined: one operation in flight at a time.

Parameters:
- DW, 18, divisor/quotient/remainder width; dividend width is 2*DW.
- OUTREG, 1, 1 = quotient/remainder/flags held in output registers until consumed; 0 = outputs are valid only while out_valid=1.

Ports:
- CLK  in  1  single clock, rising edge.
- RSTN  in  1  reset, synchronous, active-low.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  block idle; can accept operands.
- dividend  in  2*DW  unsigned dividend.
- divisor  in  DW  unsigned divisor.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer takes result.
- quotient  out  DW  unsigned quotient.
- remainder  out  DW  unsigned remainder.
- div_by_zero  out  1  divisor was 0.
- overflow  out  1  true quotient does not fit in DW bits.

Behaviour:
- Reset (RSTN=0 at a rising edge):
  - State goes to IDLE.
  - out_valid, quotient, remainder, div_by_zero and overflow are all 0.
  - Any in-flight operation is discarded.
  - in_ready=0 while RSTN=0.
- States:
  - IDLE: in_ready=1. On in_valid&in_ready, latch dividend and divisor, clear the flags, go to CHECK.
  - CHECK (1 cycle), evaluated in this order:
    - divisor==0: div_by_zero=1, quotient=all ones, remainder=dividend[DW-1:0], go to DONE.
    - else dividend[2DW-1:DW] >= divisor: overflow=1, quotient=all ones, remainder=0, go to DONE.
    - else load partial remainder (DW+1 bits) = {1'b0, dividend[2DW-1:DW]}, shift register = dividend[DW-1:0], iteration counter=0, go to RUN.
  - RUN (exactly DW cycles), each cycle:
    - Form trial = {partial remainder[DW-1:0], next dividend MSB}.
    - If trial >= divisor: partial remainder = trial - divisor, quotient bit = 1; else partial remainder = trial, quotient bit = 0.
    - Quotient bits shift in MSB-first.
    - When the counter reaches DW-1, go to DONE.
  - DONE: out_valid=1. quotient, remainder and flags stay stable until out_valid&out_ready; then go to IDLE on the next edge.
- Latency, counting the acceptance edge as k:
  - Normal division: out_valid=1 after edge k+DW+1, i.e. k+19 for DW=18.
  - Error cases: out_valid=1 after edge k+1.
  - Minimum accept-to-accept spacing: DW+3 cycles.
- Handshake:
  - in_ready=0 in CHECK, RUN and DONE. in_valid and the operand inputs are ignored there; operands may change freely.
  - out_valid never drops without out_ready. Outputs do not change while out_valid=1 and out_ready=0.
  - out_ready while out_valid=0 has no effect.
  - No same-cycle return from DONE to accept: in_ready rises the cycle after the transfer.
- Output hold:
  - OUTREG=1: quotient, remainder and flags hold their last values in IDLE.
  - OUTREG=0: they are driven to 0 whenever out_valid=0.
- Arithmetic:
  - All unsigned.
  - Invariant for valid results: dividend == quotient*divisor + remainder, and remainder < divisor.
  - The DW+1-bit partial remainder prevents loss of the carry bit when divisor > 2^(DW-1).

Test Plan:
- Basic division: dividend=1000, divisor=7 -> quotient=142, remainder=6, flags 0. out_valid rises exactly 19 edges after acceptance; in_ready=0 throughout.
- Maximum legal operands: dividend=68719214591, divisor=262143 -> quotient=262143, remainder=262142, overflow=0. Also dividend=262144, divisor=1 -> overflow=1, quotient=18'h3FFFF, remainder=0, out_valid 1 edge after the CHECK edge.
- Divide by zero: dividend=36'h0_0000_1234, divisor=0 -> div_by_zero=1, overflow=0, quotient=18'h3FFFF, remainder=18'h01234. Total latency 2 edges.
- Backpressure: out_ready held low for 5 cycles after out_valid. Outputs stay stable; in_valid pulses during this window are not accepted. out_ready=1 -> out_valid falls next edge and in_ready rises.
- Reset mid-operation: RSTN=0 for one edge at RUN iteration 9 -> all outputs are 0 and in_ready=1 after release. A new operation 100/10 then yields quotient=10, remainder=0.
- Random regression: 10k random operand pairs with random out_ready. Check the invariant against a reference model, flag correctness, and one result per acceptance.
